// File: rtl/row_vnu_mf_scheduler_if.sv
// Bus bundle between the c2v producer / VNU datapath side and the row scheduler.
// The master drives write requests and returning hard decisions; the slave (scheduler) drives the rest.
interface row_vnu_mf_scheduler_if #(
    parameter int QUAN_SIZE       = 4,
    parameter int CN_DEGREE       = 10,
    parameter int VN_DEGREE       = 3,
    parameter int MULTI_FRAME_NUM = 2,
    parameter int FRAME_BW        = 1,
    parameter int MSG_BW          = CN_DEGREE * VN_DEGREE * QUAN_SIZE
);
    logic [MSG_BW-1:0]                    c2v_in;
    logic                                 c2v_valid;
    logic [FRAME_BW-1:0]                  c2v_frame;
    logic                                 c2v_ready;
    logic [MSG_BW-1:0]                    c2v_out;
    logic                                 issue_valid;
    logic [FRAME_BW-1:0]                  read_addr_offset;
    logic [CN_DEGREE-1:0]                 hd_in;
    logic [CN_DEGREE*MULTI_FRAME_NUM-1:0] hd_out;
    logic                                 hd_update;
    logic [FRAME_BW-1:0]                  hd_frame;
    logic [MULTI_FRAME_NUM-1:0]           hd_stable;

    modport master (
        output c2v_in, c2v_valid, c2v_frame, hd_in,
        input  c2v_ready, c2v_out, issue_valid, read_addr_offset,
        input  hd_out, hd_update, hd_frame, hd_stable
    );

    modport slave (
        input  c2v_in, c2v_valid, c2v_frame, hd_in,
        output c2v_ready, c2v_out, issue_valid, read_addr_offset,
        output hd_out, hd_update, hd_frame, hd_stable
    );
endinterface

// File: rtl/row_vnu_mf_scheduler.sv
// Multi-frame c2v row buffer with round-robin issue to the partial-VNU row, plus a latency-matched
// tag pipeline that captures returning hard decisions per frame and flags their stability.
module row_vnu_mf_scheduler #(
    parameter int QUAN_SIZE       = 4,
    parameter int CN_DEGREE       = 10,
    parameter int VN_DEGREE       = 3,
    parameter int MULTI_FRAME_NUM = 2,
    parameter int FRAME_BW        = 1,
    parameter int DP_LATENCY      = 9,
    parameter int MSG_BW          = CN_DEGREE * VN_DEGREE * QUAN_SIZE
) (
    input  logic                   read_clk,
    input  logic                   rstn,
    input  logic                   clear_iter,
    row_vnu_mf_scheduler_if.slave  bus
);

    logic [MULTI_FRAME_NUM-1:0]             full;
    logic [FRAME_BW-1:0]                    rr_ptr;
    logic [MSG_BW-1:0]                      slot_mem [MULTI_FRAME_NUM];
    logic                                   wr_en;
    logic                                   issue_hit;
    logic [DP_LATENCY-1:0]                  vld_p;
    logic [DP_LATENCY-1:0][FRAME_BW-1:0]    frm_p;
    logic [MULTI_FRAME_NUM-1:0]             seen;
    logic                                   tail_vld;
    logic [FRAME_BW-1:0]                    tail_frm;
    logic [CN_DEGREE-1:0]                   tail_prev;

    // Ready is suppressed during clear so a same-cycle write can never mark a slot full.
    assign bus.c2v_ready = ~full[bus.c2v_frame] & ~clear_iter;
    assign wr_en         = bus.c2v_valid & bus.c2v_ready;
    assign issue_hit     = full[rr_ptr];

    assign tail_vld  = vld_p[DP_LATENCY-1];
    assign tail_frm  = frm_p[DP_LATENCY-1];
    assign tail_prev = bus.hd_out[tail_frm*CN_DEGREE +: CN_DEGREE];

    // Slot storage carries data only; occupancy lives in full[].
    always_ff @(posedge read_clk) begin
        if (wr_en) begin
            slot_mem[bus.c2v_frame] <= bus.c2v_in;
        end
    end

    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            full                 <= '0;
            rr_ptr               <= '0;
            vld_p                <= '0;
            frm_p                <= '0;
            seen                 <= '0;
            bus.c2v_out          <= '0;
            bus.issue_valid      <= 1'b0;
            bus.read_addr_offset <= '0;
            bus.hd_out           <= '0;
            bus.hd_update        <= 1'b0;
            bus.hd_frame         <= '0;
            bus.hd_stable        <= '0;
        end else if (clear_iter) begin
            full            <= '0;
            rr_ptr          <= '0;
            vld_p           <= '0;
            seen            <= '0;
            bus.hd_stable   <= '0;
            bus.issue_valid <= 1'b0;
            bus.hd_update   <= 1'b0;
        end else begin
            // p0: round-robin issue; pointer advances every cycle regardless of occupancy
            rr_ptr <= rr_ptr + FRAME_BW'(1);
            if (issue_hit) begin
                bus.c2v_out          <= slot_mem[rr_ptr];
                bus.read_addr_offset <= rr_ptr;
                bus.issue_valid      <= 1'b1;
                full[rr_ptr]         <= 1'b0;
            end else begin
                bus.issue_valid      <= 1'b0;
            end
            if (wr_en) begin
                full[bus.c2v_frame] <= 1'b1;
            end

            // p1..pN: tag follows the registered issue through the datapath latency
            for (int i = DP_LATENCY - 1; i > 0; i--) begin
                vld_p[i] <= vld_p[i-1];
                frm_p[i] <= frm_p[i-1];
            end
            vld_p[0] <= bus.issue_valid;
            frm_p[0] <= bus.read_addr_offset;

            // Tail stage: hd_in belongs to the tagged frame this cycle
            if (tail_vld) begin
                bus.hd_out[tail_frm*CN_DEGREE +: CN_DEGREE] <= bus.hd_in;
                bus.hd_update           <= 1'b1;
                bus.hd_frame            <= tail_frm;
                bus.hd_stable[tail_frm] <= seen[tail_frm] & (bus.hd_in == tail_prev);
                seen[tail_frm]          <= 1'b1;
            end else begin
                bus.hd_update           <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_row_vnu_mf_scheduler.sv
// Randomised bench for row_vnu_mf_scheduler against a cycle-level frame/slot reference model.
module tb_row_vnu_mf_scheduler;

    localparam int Q   = 4;
    localparam int CN  = 10;
    localparam int VN  = 3;
    localparam int M   = 2;
    localparam int FB  = 1;
    localparam int L   = 9;
    localparam int MSG = CN * VN * Q;

    logic clk = 1'b0;
    logic rstn;
    logic clear_iter;

    row_vnu_mf_scheduler_if #(.QUAN_SIZE(Q), .CN_DEGREE(CN), .VN_DEGREE(VN),
                              .MULTI_FRAME_NUM(M), .FRAME_BW(FB)) bus ();

    row_vnu_mf_scheduler #(.QUAN_SIZE(Q), .CN_DEGREE(CN), .VN_DEGREE(VN), .MULTI_FRAME_NUM(M),
                           .FRAME_BW(FB), .DP_LATENCY(L)) dut (
        .read_clk   (clk),
        .rstn       (rstn),
        .clear_iter (clear_iter),
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    logic [MSG-1:0] m_slot [M];
    bit   [M-1:0]   m_full;
    int             m_rr;
    logic [MSG-1:0] m_cout;
    int             m_off;
    bit             m_iv;
    logic [CN-1:0]  m_hd [M];
    bit             m_upd;
    int             m_hdfrm;
    bit   [M-1:0]   m_stab;
    bit   [M-1:0]   m_seen;
    int             due_q [$];
    int             frm_q [$];
    int             cyc;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int f = 0; f < M; f++) begin
            m_slot[f] = '0;
            m_hd[f]   = '0;
        end
        m_full = '0; m_rr = 0; m_cout = '0; m_off = 0; m_iv = 0;
        m_upd = 0; m_hdfrm = 0; m_stab = '0; m_seen = '0;
        due_q.delete();
        frm_q.delete();
    endtask

    // One clock edge of the model; inputs are those held during the cycle ending at this edge.
    task automatic model_edge(input bit v, input int fr, input logic [MSG-1:0] d,
                              input logic [CN-1:0] h, input bit clr);
        bit [M-1:0] old_full;
        int f;
        if (clr) begin
            m_full = '0; m_seen = '0; m_stab = '0; m_iv = 0; m_upd = 0; m_rr = 0;
            due_q.delete();
            frm_q.delete();
        end else begin
            old_full = m_full;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                f         = frm_q[0];
                m_stab[f] = m_seen[f] && (h == m_hd[f]);
                m_hd[f]   = h;
                m_seen[f] = 1'b1;
                m_upd     = 1'b1;
                m_hdfrm   = f;
                void'(due_q.pop_front());
                void'(frm_q.pop_front());
            end else begin
                m_upd = 1'b0;
            end
            if (m_full[m_rr]) begin
                m_cout       = m_slot[m_rr];
                m_off        = m_rr;
                m_iv         = 1'b1;
                m_full[m_rr] = 1'b0;
                due_q.push_back(cyc + 1 + L);
                frm_q.push_back(m_rr);
            end else begin
                m_iv = 1'b0;
            end
            if (v && !old_full[fr]) begin
                m_slot[fr] = d;
                m_full[fr] = 1'b1;
            end
            m_rr = (m_rr + 1) % M;
        end
        cyc++;
    endtask

    task automatic check_outputs();
        logic [CN*M-1:0] e_hd;
        for (int f = 0; f < M; f++) e_hd[f*CN +: CN] = m_hd[f];
        chk("c2v_out",          128'(bus.c2v_out),          128'(m_cout));
        chk("issue_valid",      128'(bus.issue_valid),      128'(m_iv));
        chk("read_addr_offset", 128'(bus.read_addr_offset), 128'(m_off));
        chk("hd_out",           128'(bus.hd_out),           128'(e_hd));
        chk("hd_update",        128'(bus.hd_update),        128'(m_upd));
        chk("hd_frame",         128'(bus.hd_frame),         128'(m_hdfrm));
        chk("hd_stable",        128'(bus.hd_stable),        128'(m_stab));
    endtask

    // Called at posedge+1: drive, check ready, advance model, wait one edge, check outputs.
    task automatic step(input bit v, input int fr, input logic [MSG-1:0] d,
                        input logic [CN-1:0] h, input bit clr);
        bus.c2v_valid = v;
        bus.c2v_frame = fr[FB-1:0];
        bus.c2v_in    = d;
        bus.hd_in     = h;
        clear_iter    = clr;
        #1;
        chk("c2v_ready", 128'(bus.c2v_ready), 128'(!m_full[fr] && !clr));
        model_edge(v, fr, d, h, clr);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n, input logic [CN-1:0] h, output int upd);
        upd = 0;
        for (int i = 0; i < n; i++) begin
            step(1'b0, i % M, '0, h, 1'b0);
            upd += int'(bus.hd_update);
        end
    endtask

    function automatic logic [MSG-1:0] rand_row();
        logic [127:0] w;
        w = {$urandom(), $urandom(), $urandom(), $urandom()};
        return w[MSG-1:0];
    endfunction

    initial begin
        logic [MSG-1:0] row_a5;
        logic [MSG-1:0] row_x;
        logic [CN-1:0]  h;
        int upd;

        rstn = 1'b0; clear_iter = 1'b0;
        bus.c2v_valid = 1'b0; bus.c2v_frame = '0; bus.c2v_in = '0; bus.hd_in = '0;
        cyc = 0;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Idle after reset: everything quiet, every slot ready
        idle(20, 10'h3FF, upd);
        chk("idle_no_update", 128'(upd), 128'(0));

        // Single row to frame 0 with rr_ptr at 0
        row_a5 = {15{8'hA5}};
        step(1'b1, 0, row_a5, 10'h155, 1'b0);
        step(1'b0, 1, '0, 10'h155, 1'b0);
        chk("iv_low_t1", 128'(bus.issue_valid), 128'(0));
        step(1'b0, 0, '0, 10'h155, 1'b0);
        chk("iv_high_t2", 128'(bus.issue_valid), 128'(1));
        chk("row_a5", 128'(bus.c2v_out), 128'(row_a5));
        idle(9, 10'h155, upd);
        chk("upd_early", 128'(upd), 128'(0));
        step(1'b0, 0, '0, 10'h155, 1'b0);
        chk("upd_at_lat", 128'(bus.hd_update), 128'(1));
        chk("hd0_155", 128'(bus.hd_out[CN-1:0]), 128'(10'h155));
        idle(4, 10'h155, upd);

        // Two iterations on both frames with identical decisions
        for (int it = 0; it < 2; it++) begin
            step(1'b1, 0, rand_row(), 10'h0F3, 1'b0);
            step(1'b1, 1, rand_row(), 10'h0F3, 1'b0);
            idle(14, 10'h0F3, upd);
            chk("iter_updates", 128'(upd), 128'(2));
        end
        chk("stable_11", 128'(bus.hd_stable), 128'(2'b11));
        step(1'b1, 1, rand_row(), 10'h0F0, 1'b0);
        idle(14, 10'h0F0, upd);
        chk("stable_01", 128'(bus.hd_stable), 128'(2'b01));

        // Second write to an occupied slot is refused
        row_x = rand_row();
        step(1'b1, 1, row_x, 10'h000, 1'b0);
        step(1'b1, 1, ~row_x, 10'h000, 1'b0);
        idle(3, 10'h000, upd);
        chk("dup_first_kept", 128'(bus.c2v_out), 128'(row_x));
        idle(12, 10'h000, upd);

        // Clear with two tags in flight
        step(1'b1, 0, rand_row(), 10'h111, 1'b0);
        step(1'b1, 1, rand_row(), 10'h111, 1'b0);
        idle(5, 10'h111, upd);
        step(1'b1, 0, rand_row(), 10'h222, 1'b1);
        chk("clear_stable", 128'(bus.hd_stable), 128'(0));
        idle(15, 10'h222, upd);
        chk("no_upd_after_clear", 128'(upd), 128'(0));
        step(1'b1, 0, rand_row(), 10'h333, 1'b0);
        idle(14, 10'h333, upd);
        chk("post_clear_capture", 128'(upd), 128'(1));

        // Randomised traffic with occasional clears
        for (int i = 0; i < 1500; i++) begin
            h = ($urandom_range(0, 2) == 0) ? 10'h155 : 10'h2AA;
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, M - 1)), rand_row(), h,
                 ($urandom_range(0, 99) == 0));
        end
        idle(20, 10'h000, upd);

        // Asynchronous reset in the middle of the pipeline
        step(1'b1, 0, rand_row(), 10'h0AA, 1'b0);
        step(1'b1, 1, rand_row(), 10'h0AA, 1'b0);
        idle(4, 10'h0AA, upd);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(20, 10'h0AA, upd);
        chk("no_cap_after_rst", 128'(upd), 128'(0));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
